// File: rtl/spram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM with a registered output stage; push-to-out_valid is 3 cycles when empty.
// Backpressure: in_ready drops when the RAM is full or in the cycle a prefetch read claims the port.
module spram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_mode,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              rd_go;
    logic              wr_go;

    // Prefetch ignores out_ready so in_ready never depends combinationally on it.
    assign rd_go    = (state == IDLE) && (cnt != '0) && !out_valid && !rst;
    assign in_ready = !rst && (cnt < CNT_MAX) && !rd_go;
    assign wr_go    = in_valid && in_ready;

    assign ram_mode = !wr_go;
    assign ram_addr = wr_go ? wr_ptr : rd_ptr;
    assign ram_din  = in_data;

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_go) state_next = RD_WAIT;
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_go) wr_ptr <= wr_ptr + 1'b1;
            if (rd_go) rd_ptr <= rd_ptr + 1'b1;
            // rd_go and wr_go are mutually exclusive through in_ready.
            case ({wr_go, rd_go})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (state == RD_WAIT) begin
            out_valid <= 1'b1;
            out_data  <= ram_dout;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign level = cnt + (ADDR_W+1)'(state == RD_WAIT) + (ADDR_W+1)'(out_valid);
    assign full  = (cnt == CNT_MAX);
    assign empty = (level == '0);

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Randomized bench: behavioural 8x8 RAM plus a queue-based reference model of the FIFO.
module tb_spram_fifo_ctrl;

    logic       clock = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] ram_din;
    logic [2:0] ram_addr;
    logic       ram_mode;
    logic [7:0] ram_dout;
    logic [3:0] level;
    logic       full;
    logic       empty;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    spram_fifo_ctrl #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
        .clock(clock), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_din(ram_din), .ram_addr(ram_addr), .ram_mode(ram_mode), .ram_dout(ram_dout),
        .level(level), .full(full), .empty(empty)
    );

    // Behavioural single-port RAM with registered read data.
    logic [7:0] mem [8];
    always @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
            ram_dout <= 8'h00;
        end else if (!ram_mode) begin
            mem[ram_addr] <= ram_din;
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    // Reference model: RAM contents as a queue, one in-flight slot, one output slot.
    logic [7:0] ram_q[$];
    int         m_infl = 0;
    logic [7:0] m_infl_d = 8'h00;
    int         m_ov = 0;
    logic [7:0] m_od = 8'h00;
    int         wr_n = 0;
    int         rd_n = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [7:0] id,
                        input logic ordy, output logic acc);
        logic e_rd, e_rdy, e_wr;
        int   lvl;
        rst = r; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        e_rd  = (m_infl == 0) && (ram_q.size() != 0) && (m_ov == 0) && !r;
        e_rdy = !r && (ram_q.size() < 8) && !e_rd;
        e_wr  = iv && e_rdy;
        lvl   = ram_q.size() + m_infl + m_ov;
        chk_eq("in_ready", 32'(in_ready), 32'(e_rdy));
        chk_eq("ram_mode", 32'(ram_mode), 32'(!e_wr));
        chk_eq("ram_addr", 32'(ram_addr), e_wr ? 32'(wr_n % 8) : 32'(rd_n % 8));
        if (e_wr) chk_eq("ram_din", 32'(ram_din), 32'(id));
        chk_eq("out_valid", 32'(out_valid), 32'(m_ov));
        chk_eq("out_data", 32'(out_data), 32'(m_od));
        chk_eq("level", 32'(level), 32'(lvl));
        chk_eq("full", 32'(full), 32'(ram_q.size() == 8));
        chk_eq("empty", 32'(empty), 32'(lvl == 0));
        @(posedge clock);
        if (r) begin
            ram_q.delete();
            m_infl = 0; m_ov = 0; m_od = 8'h00; wr_n = 0; rd_n = 0;
        end else begin
            if (m_ov != 0 && ordy) m_ov = 0;
            if (m_infl != 0) begin
                m_ov = 1; m_od = m_infl_d; m_infl = 0;
            end
            if (e_rd) begin
                m_infl = 1; m_infl_d = ram_q.pop_front(); rd_n++;
            end
            if (e_wr) begin
                ram_q.push_back(id); wr_n++;
            end
        end
        acc = e_wr;
        @(negedge clock);
    endtask

    initial begin
        logic       acc;
        logic [7:0] d;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset then idle.
        step(1'b1, 1'b0, 8'h00, 1'b0, acc);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, acc);

        // Single push, held in the output register.
        step(1'b0, 1'b1, 8'hA5, 1'b0, acc);
        chk_eq("push_a5_acc", 32'(acc), 32'd1);
        repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0, acc);

        // Fill from empty: 0x10..0x18, then a 10th push that must stall.
        step(1'b1, 1'b0, 8'h00, 1'b0, acc);
        d = 8'h10;
        for (int i = 0; i < 40 && d <= 8'h18; i++) begin
            step(1'b0, 1'b1, d, 1'b0, acc);
            if (acc) d++;
        end
        chk_eq("fill_done", 32'(d), 32'h19);
        repeat (5) step(1'b0, 1'b1, 8'h19, 1'b0, acc);

        // Drain in order; pointers wrap to 1.
        for (int i = 0; i < 35; i++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

        // Collision: continuous push while the output register turns over.
        for (int i = 0; i < 60; i++)
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), acc);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

        // Reset during the in-flight read.
        step(1'b0, 1'b1, 8'h77, 1'b0, acc);
        for (int i = 0; i < 5 && m_infl == 0; i++) step(1'b0, 1'b0, 8'h00, 1'b0, acc);
        chk_eq("mid_read_reached", 32'(m_infl), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, acc);
        step(1'b0, 1'b0, 8'h00, 1'b0, acc);
        step(1'b0, 1'b1, 8'h3C, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0, acc);
        chk_eq("pop_3c", 32'(out_data), 32'h3C);
        step(1'b0, 1'b0, 8'h00, 1'b1, acc);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) != 0), acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spram_fifo_ctrl.md
Name: spram_fifo_ctrl

Overview:
- FIFO controller that drives the team's 8x8 single-port RAM: ram_din, ram_addr, ram_mode out; ram_dout in.
- Upstream side is a valid/ready push interface. Downstream side is a valid/ready pop interface with a one-entry output holding register.
- The RAM port performs exactly one operation per cycle. This block arbitrates between writes and prefetch reads, and keeps the RAM in read mode whenever it is not writing.

Parameters:
- DATA_W, 8, data width; must match RAM width.
- ADDR_W, 3, RAM address width.
- DEPTH, 8, RAM entries; must equal 2**ADDR_W.

Ports:
- clock  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset; also wired to the RAM rst.
- in_data  input  DATA_W  push data.
- in_valid  input  1  push request.
- in_ready  output  1  push accepted when in_valid && in_ready at a clock edge.
- out_data  output  DATA_W  head-of-FIFO data (registered).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  pop when out_valid && out_ready at a clock edge.
- ram_din  output  DATA_W  RAM write data.
- ram_addr  output  ADDR_W  RAM address.
- ram_mode  output  1  0 = write, 1 = read.
- ram_dout  input  DATA_W  RAM registered read data.
- level  output  ADDR_W+1  total entries held: RAM + in-flight read + output register; maximum DEPTH+1.
- full  output  1  RAM count == DEPTH.
- empty  output  1  level == 0.

Behaviour:
- RAM contract:
  - ram_mode=0 writes ram_din to mem[ram_addr] at the clock edge.
  - ram_mode=1 loads ram_dout with mem[ram_addr] at the edge; ram_dout is valid the following cycle.
  - While rst is high the RAM clears its contents and ignores ram_mode.
- State:
  - wr_ptr and rd_ptr: ADDR_W bits each, wrap DEPTH-1 -> 0 naturally.
  - cnt: 0..DEPTH, entries in RAM only.
  - FSM: IDLE, RD_WAIT.
  - out_data/out_valid holding register.
- rd_go = (state==IDLE) && cnt!=0 && !out_valid && !rst.
  - No out_ready dependency, so there is no combinational path from out_ready to in_ready.
- wr_go = in_valid && in_ready.
- in_ready = !rst && cnt<DEPTH && !rd_go. Reads have priority over writes; in_ready drops for the cycle a read issues.
- RAM drive (combinational):
  - ram_mode = !wr_go.
  - ram_addr = wr_go ? wr_ptr : rd_ptr.
  - ram_din = in_data.
  - When neither operation is active: ram_mode=1, ram_addr=rd_ptr (harmless read).
- FSM transitions:
  - IDLE -> RD_WAIT on rd_go: rd_ptr+1, cnt-1.
  - RD_WAIT -> IDLE unconditionally: out_data <= ram_dout, out_valid <= 1.
  - A write may occur in RD_WAIT because the port is free that cycle.
- wr_go: wr_ptr+1, cnt+1.
  - rd_go and wr_go are never both high, so cnt never increments and decrements in the same cycle.
- Pop: out_valid && out_ready clears out_valid; out_data holds its last value.
  - The next read issues in the following cycle at the earliest.
- Latency:
  - Push to out_valid is 3 cycles when the FIFO is empty: write at edge N, read issues cycle N+1, out_valid high after edge N+2.
  - Sustained pop throughput is one entry per 3 cycles. Sustained push rate is one per cycle when no reads are pending.
- full when cnt==DEPTH: in_ready=0 and no write is issued. This is independent of the output register, so level can reach DEPTH+1.
- Pointer wrap: after 8 pushes, wr_ptr returns to 0. Ordering is preserved across wrap.
- Write-then-read at the same address is safe: a read is only issued when cnt>0, i.e. after the write edge.
- Reset (synchronous):
  - Register values: wr_ptr=0, rd_ptr=0, cnt=0, state=IDLE, out_valid=0, out_data=0.
  - Outputs during rst: in_ready=0, ram_mode=1.
  - Derived flags after reset: level=0, full=0, empty=1.
  - Reset in RD_WAIT discards the in-flight read.
  - Reset has priority over every push and pop in the same cycle.

Test Plan:
- Reset then idle: rst 2 cycles -> out_valid=0, out_data=0, level=0, empty=1, in_ready=1 after release; ram_mode=1 every idle cycle.
- Single push 0xA5 with out_ready=0 -> ram_mode=0, ram_addr=0 at the push edge; a read of addr 0 the next cycle; out_valid=1, out_data=0xA5 two cycles after the push; level=1.
- Fill:
  - Push 0x10..0x18 with out_ready=0 -> first word lands in the output register.
  - in_ready falls when cnt==8; level=9, full=1.
  - 10th push stalls with no ram_mode=0 cycle.
- Drain with out_ready=1 -> pops 0x10..0x18 in order, one per 3 cycles; empty=1 at end; wr_ptr/rd_ptr both wrapped to 1.
- Collision: in_valid=1 continuously while the output register empties with cnt>0 -> in_ready=0 exactly in the rd_go cycle; the write lands in RD_WAIT; no data lost or reordered.
- Reset mid-read: assert rst during RD_WAIT -> out_valid stays 0, level=0; a subsequent push 0x3C pops as 0x3C.
